// File: rtl/pwm_capture_pkg.sv
// pwm_capture shared definitions.
// FSM encoding and duty width shared with the PWM generator.
package pwm_capture_pkg;

  localparam int DUTY_W        = 16;
  localparam int DUTY_PREC_DEF = 1000;

  typedef enum logic [1:0] {
    ST_ARM       = 2'd0,
    ST_WAIT_RISE = 2'd1,
    ST_HIGH      = 2'd2,
    ST_LOW       = 2'd3
  } cap_state_t;

endpackage

// File: rtl/pwm_duty_div.sv
// pwm_duty_div: restoring divider, one quotient bit per cycle.
// busy covers the load, the iterations and the done cycle.
module pwm_duty_div #(
  parameter int NUM_W = 48,
  parameter int DEN_W = 32,
  parameter int Q_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [NUM_W-1:0] num,
  input  logic [DEN_W-1:0] den,
  output logic             busy,
  output logic             done,
  output logic [Q_W-1:0]   quo
);

  localparam int CW = $clog2(Q_W + 1);

  logic [NUM_W-1:0] rem;
  logic [NUM_W-1:0] dsh;
  logic [NUM_W-1:0] rem_sub;
  logic [CW-1:0]    cnt;
  logic             fit;

  // trial subtraction of the shifted divisor
  always_comb begin
    fit     = rem >= dsh;
    rem_sub = rem - dsh;
  end

  // load, iterate MSB-first, then one done cycle
  always_ff @(posedge clk) begin
    if (rst || abort) begin
      busy <= 1'b0;
      done <= 1'b0;
      cnt  <= '0;
      rem  <= '0;
      dsh  <= '0;
      quo  <= '0;
    end else if (done) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else if (cnt != '0) begin
      rem <= fit ? rem_sub : rem;
      quo <= {quo[Q_W-2:0], fit};
      dsh <= dsh >> 1;
      cnt <= cnt - CW'(1);
      if (cnt == CW'(1)) done <= 1'b1;
    end else if (start) begin
      busy <= 1'b1;
      rem  <= num;
      dsh  <= NUM_W'(den) << (Q_W - 1);
      quo  <= '0;
      cnt  <= CW'(Q_W);
    end
  end

endmodule

// File: rtl/pwm_capture.sv
// pwm_capture: measures period, high time and duty of a PWM pin.
// Also flags a stuck line after TIMEOUT_CYC cycles without edges.
module pwm_capture import pwm_capture_pkg::*; #(
  parameter int CNT_W       = 32,
  parameter int DUTY_PREC   = DUTY_PREC_DEF,
  parameter int TIMEOUT_CYC = 50_000_000,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pwm_in,
  output logic [CNT_W-1:0]  period_cyc,
  output logic [CNT_W-1:0]  high_cyc,
  output logic [DUTY_W-1:0] duty,
  output logic              meas_valid,
  output logic              busy,
  output logic              stuck,
  output logic              stuck_level
);

  localparam int NUM_W = CNT_W + DUTY_W;
  localparam int AW    = $clog2(SYNC_STAGES + 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   s_in, s_d;
  logic                   rise, fall, any_edge;
  logic [CNT_W-1:0]       idle_cnt;
  logic                   tmo;
  logic [AW-1:0]          arm_cnt;
  logic                   arm_done;
  cap_state_t             state, state_nx;
  logic                   cnt_start, per_inc, hi_inc, capture;
  logic [CNT_W-1:0]       per_cnt, hi_cnt;
  logic [CNT_W-1:0]       cap_per, cap_hi;
  logic                   div_start, div_busy, div_done;
  logic [DUTY_W-1:0]      div_quo;

  assign s_in     = sync[SYNC_STAGES-1];
  assign rise     = s_in & ~s_d;
  assign fall     = ~s_in & s_d;
  assign any_edge = rise | fall;
  assign tmo      = !any_edge &&
                    (idle_cnt == CNT_W'(TIMEOUT_CYC - 1));
  assign arm_done = arm_cnt == AW'(SYNC_STAGES);
  assign div_start = capture && !div_busy;
  assign busy     = div_busy;

  // input synchronizer and edge-detect delay
  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= '0;
      s_d  <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], pwm_in};
      s_d  <= s_in;
    end
  end

  // cycles since last edge, saturating
  always_ff @(posedge clk) begin
    if (rst || any_edge || tmo)
      idle_cnt <= '0;
    else if (idle_cnt != '1)
      idle_cnt <= idle_cnt + CNT_W'(1);
  end

  // ARM hold: let the synchronizer fill before trusting s_in
  always_ff @(posedge clk) begin
    if (rst || state != ST_ARM)
      arm_cnt <= '0;
    else if (!arm_done)
      arm_cnt <= arm_cnt + AW'(1);
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_ARM;
    else     state <= state_nx;
  end

  // FSM next state; timeout overrides everything
  always_comb begin
    state_nx = state;
    if (tmo) begin
      state_nx = s_in ? ST_ARM : ST_WAIT_RISE;
    end else begin
      unique case (state)
        ST_ARM:       if (arm_done && !s_in) state_nx = ST_WAIT_RISE;
        ST_WAIT_RISE: if (rise) state_nx = ST_HIGH;
        ST_HIGH:      if (fall) state_nx = ST_LOW;
        ST_LOW:       if (rise) state_nx = ST_HIGH;
        default:      state_nx = ST_ARM;
      endcase
    end
  end

  // FSM outputs: counter control and capture strobe
  always_comb begin
    cnt_start = 1'b0;
    per_inc   = 1'b0;
    hi_inc    = 1'b0;
    capture   = 1'b0;
    if (!tmo) begin
      unique case (state)
        ST_WAIT_RISE: cnt_start = rise;
        ST_HIGH: begin
          per_inc = 1'b1;
          hi_inc  = !fall;
        end
        ST_LOW: begin
          per_inc   = !rise;
          capture   = rise;
          cnt_start = rise;
        end
        default: ;
      endcase
    end
  end

  // period and high counters, saturating
  always_ff @(posedge clk) begin
    if (rst) begin
      per_cnt <= '0;
      hi_cnt  <= '0;
    end else if (cnt_start) begin
      per_cnt <= CNT_W'(1);
      hi_cnt  <= CNT_W'(1);
    end else begin
      if (per_inc && per_cnt != '1)
        per_cnt <= per_cnt + CNT_W'(1);
      if (hi_inc && hi_cnt != '1)
        hi_cnt <= hi_cnt + CNT_W'(1);
    end
  end

  // hold the sample being divided until it is published
  always_ff @(posedge clk) begin
    if (rst) begin
      cap_per <= '0;
      cap_hi  <= '0;
    end else if (div_start) begin
      cap_per <= per_cnt;
      cap_hi  <= hi_cnt;
    end
  end

  pwm_duty_div #(
    .NUM_W (NUM_W),
    .DEN_W (CNT_W),
    .Q_W   (DUTY_W)
  ) u_div (
    .clk   (clk),
    .rst   (rst),
    .start (div_start),
    .abort (tmo),
    .num   (NUM_W'(hi_cnt) * NUM_W'(DUTY_PREC)),
    .den   (per_cnt),
    .busy  (div_busy),
    .done  (div_done),
    .quo   (div_quo)
  );

  // output registers; timeout beats a finishing division
  always_ff @(posedge clk) begin
    if (rst) begin
      period_cyc  <= '0;
      high_cyc    <= '0;
      duty        <= '0;
      meas_valid  <= 1'b0;
      stuck       <= 1'b0;
      stuck_level <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      if (tmo) begin
        stuck       <= 1'b1;
        stuck_level <= s_in;
        period_cyc  <= '0;
        high_cyc    <= '0;
        duty        <= s_in ? DUTY_W'(DUTY_PREC) : '0;
      end else if (div_done) begin
        period_cyc <= cap_per;
        high_cyc   <= cap_hi;
        duty       <= div_quo;
        meas_valid <= 1'b1;
        stuck      <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: random and directed PWM against an edge-log model.
// Expected results come from driven edge times and divider occupancy.
module tb_pwm_capture;

  localparam int CNT_W = 32;
  localparam int PREC  = 1000;
  localparam int TMO   = 5000;
  localparam int LAT   = 20;
  localparam int GAP   = 18;

  logic        clk = 1'b0;
  logic        rst;
  logic        pwm_in;
  logic [31:0] period_cyc, high_cyc;
  logic [15:0] duty;
  logic        meas_valid, busy, stuck, stuck_level;

  pwm_capture #(
    .CNT_W       (CNT_W),
    .DUTY_PREC   (PREC),
    .TIMEOUT_CYC (TMO),
    .SYNC_STAGES (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pwm_in      (pwm_in),
    .period_cyc  (period_cyc),
    .high_cyc    (high_cyc),
    .duty        (duty),
    .meas_valid  (meas_valid),
    .busy        (busy),
    .stuck       (stuck),
    .stuck_level (stuck_level)
  );

  always #10 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int due;
    int p;
    int h;
  } rep_t;

  rep_t q[$];
  int   prev_rise, prev_fall, last_acc;
  bit   has_prev, has_fall;
  int   npass = 0;
  int   ntot  = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic new_epoch();
    has_prev = 1'b0;
    has_fall = 1'b0;
    last_acc = -1000000;
  endtask

  task automatic tick();
    @(negedge clk);
    if (q.size() > 0 && q[0].due == cyc) begin
      chk("meas_valid", 64'(meas_valid), 64'd1);
      chk("period", 64'(period_cyc), 64'(q[0].p));
      chk("high", 64'(high_cyc), 64'(q[0].h));
      chk("duty", 64'(duty), 64'((longint'(q[0].h) * PREC) / q[0].p));
      chk("stuck_clr", 64'(stuck), 64'd0);
      void'(q.pop_front());
    end else begin
      chk("no_meas", 64'(meas_valid), 64'd0);
    end
  endtask

  task automatic set_pin(input logic v);
    if (v && !pwm_in) begin
      if (has_prev && has_fall && cyc - last_acc >= GAP) begin
        q.push_back('{due: cyc + LAT, p: cyc - prev_rise,
                      h: prev_fall - prev_rise});
        last_acc = cyc;
      end
      prev_rise = cyc;
      has_prev  = 1'b1;
      has_fall  = 1'b0;
    end else if (!v && pwm_in && has_prev) begin
      prev_fall = cyc;
      has_fall  = 1'b1;
    end
    pwm_in = v;
  endtask

  task automatic drive_period(input int p, input int h);
    set_pin(1'b1);
    repeat (h) tick();
    set_pin(1'b0);
    repeat (p - h) tick();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_per"}, 64'(period_cyc), 64'd0);
    chk({tag, "_hi"}, 64'(high_cyc), 64'd0);
    chk({tag, "_duty"}, 64'(duty), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_stuck"}, 64'(stuck), 64'd0);
  endtask

  initial begin
    int p, h, n;
    rst    = 1'b1;
    pwm_in = 1'b0;
    new_epoch();
    repeat (3) tick();
    chk_zero("reset");
    chk("reset_lvl", 64'(stuck_level), 64'd0);
    rst = 1'b0;
    repeat (10) tick();
    chk_zero("idle");

    repeat (3) drive_period(1000, 100);
    repeat (2) drive_period(2000, 1500);
    repeat (60) drive_period(3, 1);
    repeat (6) begin
      p = $urandom_range(300, 20);
      h = $urandom_range(p - 1, 1);
      n = $urandom_range(5, 3);
      repeat (n) drive_period(p, h);
    end

    set_pin(1'b1);
    repeat (6000) tick();
    chk("stuck_hi", 64'(stuck), 64'd1);
    chk("stuck_hi_lvl", 64'(stuck_level), 64'd1);
    chk("stuck_hi_duty", 64'(duty), 64'(PREC));
    chk("stuck_hi_per", 64'(period_cyc), 64'd0);
    chk("stuck_hi_hi", 64'(high_cyc), 64'd0);
    new_epoch();

    repeat (4) drive_period(1000, 500);
    chk("resume_stuck", 64'(stuck), 64'd0);
    chk("resume_duty", 64'(duty), 64'd500);

    repeat (6000) tick();
    chk("stuck_lo", 64'(stuck), 64'd1);
    chk("stuck_lo_lvl", 64'(stuck_level), 64'd0);
    chk("stuck_lo_duty", 64'(duty), 64'd0);
    chk("stuck_lo_per", 64'(period_cyc), 64'd0);
    new_epoch();

    repeat (3) drive_period(200, 50);
    set_pin(1'b1);
    tick();
    rst = 1'b1;
    q.delete();
    new_epoch();
    tick();
    chk_zero("rst_high");
    tick();
    rst = 1'b0;
    repeat (10) tick();

    repeat (4) drive_period(300, 100);
    set_pin(1'b1);
    repeat (8) tick();
    chk("div_busy", 64'(busy), 64'd1);
    rst = 1'b1;
    q.delete();
    new_epoch();
    tick();
    chk_zero("rst_div");
    tick();
    rst = 1'b0;
    repeat (10) tick();
    repeat (4) drive_period(250, 200);

    repeat (40) tick();
    chk("drain", 64'(q.size()), 64'd0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
